// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

  // One-hot operand selects consumed by the EX-stage forwarding muxes.
  localparam logic [2:0] FWD_IDEX  = 3'b001;
  localparam logic [2:0] FWD_EXMEM = 3'b010;
  localparam logic [2:0] FWD_MEMWB = 3'b100;

  // Destination and control bits of one pipeline slot.
  typedef struct packed {
    logic [4:0] dst;
    logic       wr;
    logic       mr;
  } pipe_slot_t;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH,
    FREEZE
  } hz_mode_t;

  // A later slot supplies the operand only if it writes a nonzero register that the
  // consumer actually reads.
  function automatic logic src_hit(logic [4:0] dst, logic wr, logic [4:0] src, logic rd);
    return wr && (dst != 5'd0) && (dst == src) && rd;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side signal bundle of the hazard/forwarding controller.
interface hazard_fwd_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_reads_rs;
  logic             id_reads_rt;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [4:0]       ex_reg_dest;
  logic             flush;
  logic             mem_busy;
  logic [2:0]       fwdA;
  logic [2:0]       fwdB;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_en;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  // Pipeline datapath side.
  modport master (
    output id_rs, id_rt, id_reads_rs, id_reads_rt, id_reg_write, id_mem_read,
    output ex_reg_dest, flush, mem_busy,
    input  fwdA, fwdB, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en,
    input  stall_cycles, flush_cycles
  );

  // Hazard unit side.
  modport slave (
    input  id_rs, id_rt, id_reads_rs, id_reads_rt, id_reg_write, id_mem_read,
    input  ex_reg_dest, flush, mem_busy,
    output fwdA, fwdB, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en,
    output stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Forwarding select for one EX operand: EX_MEM beats MEM_WB, register 0 never forwards.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       src_rd_i,
  input  logic [4:0] mem_dst_i,
  input  logic       mem_wr_i,
  input  logic [4:0] wb_dst_i,
  input  logic       wb_wr_i,
  output logic [2:0] fwd_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = src_hit(mem_dst_i, mem_wr_i, src_i, src_rd_i);
  assign wb_hit  = src_hit(wb_dst_i, wb_wr_i, src_i, src_rd_i);

  // Priority encode into a one-hot select; the default keeps it one-hot.
  always_comb begin
    fwd_o = FWD_IDEX;
    if (mem_hit) begin
      fwd_o = FWD_EXMEM;
    end else if (wb_hit) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller for the five-stage pipeline. Keeps a shadow
// copy of EX/MEM/WB destinations, drives forwarding selects, load-use stall, flush and
// memory-busy freeze, and counts stall/flush cycles.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_fwd_if.slave     bus
);

  // EX slot shadow.
  logic [4:0]       ex_rs_q, ex_rt_q;
  logic             ex_rd_rs_q, ex_rd_rt_q, ex_wr_q, ex_mr_q;
  // MEM and WB slot shadows.
  logic [4:0]       mem_dst_q, wb_dst_q;
  logic             mem_wr_q, wb_wr_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  pipe_slot_t ex_view;
  logic       lu;
  hz_mode_t   mode;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en;

  // EX destination comes from the RegDst mux, control bits from the shadow.
  assign ex_view = '{dst: bus.ex_reg_dest, wr: ex_wr_q, mr: ex_mr_q};

  assign lu = ex_view.mr && (ex_view.dst != 5'd0) &&
              ((bus.id_reads_rs && (bus.id_rs == ex_view.dst)) ||
               (bus.id_reads_rt && (bus.id_rt == ex_view.dst)));

  // Mode priority: freeze, then flush (discards the ID instruction), then load-use stall.
  always_comb begin
    mode = RUN;
    if (bus.mem_busy) begin
      mode = FREEZE;
    end else if (bus.flush) begin
      mode = FLUSH;
    end else if (lu) begin
      mode = STALL;
    end
  end

  // Decode the mode into pipeline enables.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b1;
    unique case (mode)
      FREEZE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_en     = 1'b0;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Advance the shadow pipeline in step with the real pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
      ex_rd_rs_q <= 1'b0;
      ex_rd_rt_q <= 1'b0;
      ex_wr_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      mem_dst_q  <= 5'd0;
      mem_wr_q   <= 1'b0;
      wb_dst_q   <= 5'd0;
      wb_wr_q    <= 1'b0;
    end else if (pipe_en) begin
      if (id_ex_bubble) begin
        ex_rs_q    <= 5'd0;
        ex_rt_q    <= 5'd0;
        ex_rd_rs_q <= 1'b0;
        ex_rd_rt_q <= 1'b0;
        ex_wr_q    <= 1'b0;
        ex_mr_q    <= 1'b0;
      end else begin
        ex_rs_q    <= bus.id_rs;
        ex_rt_q    <= bus.id_rt;
        ex_rd_rs_q <= bus.id_reads_rs;
        ex_rd_rt_q <= bus.id_reads_rt;
        ex_wr_q    <= bus.id_reg_write;
        ex_mr_q    <= bus.id_mem_read;
      end
      mem_dst_q <= ex_view.dst;
      mem_wr_q  <= ex_view.wr;
      wb_dst_q  <= mem_dst_q;
      wb_wr_q   <= mem_wr_q;
    end
  end

  // Saturating stall/flush counters; freeze cycles are never in STALL or FLUSH mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (mode == STALL && stall_q != '1) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (mode == FLUSH && flush_q != '1) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  fwd_select u_fwd_a (
    .src_i     (ex_rs_q),
    .src_rd_i  (ex_rd_rs_q),
    .mem_dst_i (mem_dst_q),
    .mem_wr_i  (mem_wr_q),
    .wb_dst_i  (wb_dst_q),
    .wb_wr_i   (wb_wr_q),
    .fwd_o     (bus.fwdA)
  );

  fwd_select u_fwd_b (
    .src_i     (ex_rt_q),
    .src_rd_i  (ex_rd_rt_q),
    .mem_dst_i (mem_dst_q),
    .mem_wr_i  (mem_wr_q),
    .wb_dst_i  (wb_dst_q),
    .wb_wr_i   (wb_wr_q),
    .fwd_o     (bus.fwdB)
  );

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.pipe_en      = pipe_en;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_cycles = flush_q;

endmodule
